// File: rtl/hamming_reader.sv
// Read-only front end for a 7-bit Hamming(7,4) memory.
// Fetches one codeword per request, corrects single-bit errors, returns the nibble.
module hamming_reader #(
    parameter int L = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic [$clog2(L)-1:0] req_addr,
    output logic                 req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [3:0]           rsp_data,
    output logic                 rsp_corr,
    output logic [2:0]           rsp_syn,
    output logic [$clog2(L)-1:0] mem_addr,
    output logic                 mem_rw,
    output logic                 mem_oe,
    input  logic [6:0]           mem_data,
    output logic [7:0]           corr_count
);
    localparam int AW = $clog2(L);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAP,
        RSP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [AW-1:0] addr_q;
    logic [2:0]    syn;
    logic [6:0]    flip;
    logic [6:0]    fixed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (req_valid) state_nx = RD;
            RD:   state_nx = CAP;
            CAP:  state_nx = RSP;
            RSP:  if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Syndrome value is the 1-based position of the flipped bit
    always_comb begin
        syn[0] = mem_data[0] ^ mem_data[2] ^ mem_data[4] ^ mem_data[6];
        syn[1] = mem_data[1] ^ mem_data[2] ^ mem_data[5] ^ mem_data[6];
        syn[2] = mem_data[3] ^ mem_data[4] ^ mem_data[5] ^ mem_data[6];
        flip = 7'b0;
        if (syn != 3'd0) begin
            flip[syn - 3'd1] = 1'b1;
        end
        fixed = mem_data ^ flip;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q     <= '0;
            rsp_data   <= 4'd0;
            rsp_corr   <= 1'b0;
            rsp_syn    <= 3'd0;
            corr_count <= 8'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q <= req_addr;
            end
            if (state == CAP) begin
                rsp_data <= {fixed[6], fixed[5], fixed[4], fixed[2]};
                rsp_corr <= (syn != 3'd0);
                rsp_syn  <= syn;
                if (syn != 3'd0 && corr_count != 8'hff) begin
                    corr_count <= corr_count + 8'd1;
                end
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RSP);
    assign mem_oe    = (state == CAP);
    assign mem_addr  = addr_q;
    assign mem_rw    = 1'b0;

endmodule

// File: tb/tb_hamming_reader.sv
// Self-checking bench for hamming_reader: vector table, scoreboard queue,
// saturation run and mid-transaction reset.
module tb_hamming_reader;
    localparam int L  = 16;
    localparam int AW = $clog2(L);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [3:0]    rsp_data;
    logic          rsp_corr;
    logic [2:0]    rsp_syn;
    logic [AW-1:0] mem_addr;
    logic          mem_rw;
    logic          mem_oe;
    logic [6:0]    mem_data;
    logic [7:0]    corr_count;

    logic [6:0] mem [L];
    logic [6:0] emask = 7'd0;
    logic [6:0] mem_q = 7'd0;

    hamming_reader #(.L(L)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_corr   (rsp_corr),
        .rsp_syn    (rsp_syn),
        .mem_addr   (mem_addr),
        .mem_rw     (mem_rw),
        .mem_oe     (mem_oe),
        .mem_data   (mem_data),
        .corr_count (corr_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory with a forced error mask on the read path
    always @(posedge clk) mem_q <= mem[mem_addr] ^ emask;
    assign mem_data = mem_q;

    typedef struct {
        logic [AW-1:0] addr;
        logic [6:0]    word;
        logic [6:0]    mask;
        logic [3:0]    data;
        logic          corr;
        logic [2:0]    syn;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic       corr;
        logic [2:0] syn;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cc = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] w;
        w[2] = d[0];
        w[4] = d[1];
        w[5] = d[2];
        w[6] = d[3];
        w[0] = d[0] ^ d[1] ^ d[3];
        w[1] = d[0] ^ d[2] ^ d[3];
        w[3] = d[1] ^ d[2] ^ d[3];
        return w;
    endfunction

    task automatic issue(input logic [AW-1:0] a, input logic [6:0] w,
                         input logic [6:0] m, input exp_t e, input int hold);
        exp_t ex;
        int   cnt;
        int   oe;
        mem[a] = w;
        emask  = m;
        sb.push_back(e);
        if (e.corr) exp_cc = (exp_cc == 255) ? 255 : exp_cc + 1;
        cnt = 0;
        while (!req_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cnt = 0;
        oe  = 0;
        while (!rsp_valid && cnt < 10) begin
            oe += int'(mem_oe);
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, 2);
        chk("oe_pulses", oe, 1);
        ex = sb.pop_front();
        chk("rsp_data", rsp_data, ex.data);
        chk("rsp_corr", rsp_corr, ex.corr);
        chk("rsp_syn", rsp_syn, ex.syn);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_ready", req_ready, 0);
            chk("hold_oe", mem_oe, 0);
            chk("hold_data", {rsp_data, rsp_corr, rsp_syn},
                {ex.data, ex.corr, ex.syn});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 0);
        chk("back_idle", req_ready, 1);
        chk("corr_count", corr_count, exp_cc);
    endtask

    vec_t tbl[11];

    initial begin
        logic [3:0] nib;
        int         k;
        exp_t       e;
        int         stray;

        tbl[0] = '{4'd3, 7'b1010101, 7'b0000000, 4'b1011, 1'b0, 3'b000};
        tbl[1] = '{4'd3, 7'b1010101, 7'b0010000, 4'b1011, 1'b1, 3'b101};
        for (int i = 0; i < 7; i++) begin
            tbl[2+i] = '{AW'(i), 7'b0, 7'b1 << i, 4'b0, 1'b1, 3'(i + 1)};
        end
        tbl[9]  = '{4'd15, 7'b1111111, 7'b0000000, 4'b1111, 1'b0, 3'b000};
        tbl[10] = '{4'd15, 7'b1111111, 7'b0000001, 4'b1111, 1'b1, 3'b001};

        for (int i = 0; i < L; i++) mem[i] = 7'd0;

        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_oe", mem_oe, 0);
        chk("rst_mem_rw", mem_rw, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp", {rsp_data, rsp_corr, rsp_syn}, 0);
        chk("rst_corr_count", corr_count, 0);

        foreach (tbl[i]) begin
            e = '{tbl[i].data, tbl[i].corr, tbl[i].syn};
            issue(tbl[i].addr, tbl[i].word, tbl[i].mask, e, 0);
        end

        // Backpressure with a competing request held high
        e = '{4'b1011, 1'b1, 3'b101};
        issue(4'd3, 7'b1010101, 7'b0010000, e, 5);
        chk("after_hold_addr", mem_addr, 3);

        for (int i = 0; i < 260; i++) begin
            nib = 4'($urandom_range(0, 15));
            k   = $urandom_range(0, 6);
            e   = '{nib, 1'b1, 3'(k + 1)};
            issue(AW'($urandom_range(0, L - 1)), enc(nib), 7'b1 << k, e, 0);
        end
        chk("cc_saturated", corr_count, 255);
        e = '{4'b0110, 1'b1, 3'd7};
        issue(4'd9, enc(4'b0110), 7'b1000000, e, 0);
        chk("cc_holds", corr_count, 255);
        e = '{4'b0110, 1'b0, 3'd0};
        issue(4'd9, enc(4'b0110), 7'b0, e, 0);

        // Reset while a corrected word sits in CAP
        mem[5] = enc(4'b1001);
        emask  = 7'b0000100;
        req_valid = 1'b1;
        req_addr  = 4'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("cap_oe", mem_oe, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_cc = 0;
        chk("cap_rst_ready", req_ready, 1);
        chk("cap_rst_valid", rsp_valid, 0);
        chk("cap_rst_oe", mem_oe, 0);
        chk("cap_rst_cc", corr_count, 0);
        chk("cap_rst_rsp", {rsp_data, rsp_corr, rsp_syn}, 0);
        stray = 0;
        repeat (5) begin
            @(posedge clk); #1;
            stray += int'(rsp_valid) + int'(mem_oe);
        end
        chk("no_stray_rsp", stray, 0);

        e = '{4'b1001, 1'b1, 3'd3};
        issue(4'd5, enc(4'b1001), 7'b0000100, e, 0);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
